// File: rtl/operand_select_unit.sv
// Operand select mux with a registered valid/ready output stage.
// A two-entry skid buffer absorbs one extra operand when the ALU stalls.
module operand_select_unit #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    localparam int SEL_W   = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          op,
    output logic [SEL_W-1:0]          op_sel,
    output logic                      sel_err,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          xfer_cnt
);

    logic [WIDTH-1:0] mux_data;
    logic             mux_err;

    logic [WIDTH-1:0] out_data;
    logic [SEL_W-1:0] out_sel;
    logic             out_err;
    logic             out_v;

    logic [WIDTH-1:0] skid_data;
    logic [SEL_W-1:0] skid_sel;
    logic             skid_err;
    logic             skid_v;

    logic [CNT_W-1:0] cnt;
    logic             acc;
    logic             xfer;

    // Unmatched selects yield zero data with the error flag set.
    always_comb begin
        mux_data = '0;
        mux_err  = 1'b1;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel == SEL_W'(k)) begin
                mux_data = d[k*WIDTH +: WIDTH];
                mux_err  = 1'b0;
            end
        end
    end

    assign acc  = in_valid && !skid_v;
    assign xfer = out_v && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_err   <= 1'b0;
            out_v     <= 1'b0;
            skid_data <= '0;
            skid_sel  <= '0;
            skid_err  <= 1'b0;
            skid_v    <= 1'b0;
            cnt       <= '0;
        end else begin
            if (xfer) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (!out_v || xfer) begin
                if (skid_v) begin
                    out_data <= skid_data;
                    out_sel  <= skid_sel;
                    out_err  <= skid_err;
                    out_v    <= 1'b1;
                    skid_v   <= 1'b0;
                end else if (acc) begin
                    out_data <= mux_data;
                    out_sel  <= sel;
                    out_err  <= mux_err;
                    out_v    <= 1'b1;
                end else begin
                    out_v <= 1'b0;
                end
            end else if (acc) begin
                skid_data <= mux_data;
                skid_sel  <= sel;
                skid_err  <= mux_err;
                skid_v    <= 1'b1;
            end
        end
    end

    assign in_ready  = !skid_v;
    assign op        = out_data;
    assign op_sel    = out_sel;
    assign sel_err   = out_err;
    assign out_valid = out_v;
    assign xfer_cnt  = cnt;

endmodule

// File: tb/tb_operand_select_unit.sv
// Bench for operand_select_unit: directed vectors, hand sequences and
// random traffic checked against a queue-based reference model.
module tb_operand_select_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 8-bit, 4 channels, 16-bit counter
    logic        a_rst;
    logic [31:0] a_d;
    logic [1:0]  a_sel;
    logic        a_in_valid, a_in_ready;
    logic [7:0]  a_op;
    logic [1:0]  a_op_sel;
    logic        a_sel_err, a_out_valid, a_out_ready;
    logic [15:0] a_xfer_cnt;

    // Instance B: 8-bit, 3 channels, 4-bit counter
    logic        b_rst;
    logic [23:0] b_d;
    logic [1:0]  b_sel;
    logic        b_in_valid, b_in_ready;
    logic [7:0]  b_op;
    logic [1:0]  b_op_sel;
    logic        b_sel_err, b_out_valid, b_out_ready;
    logic [3:0]  b_xfer_cnt;

    operand_select_unit #(.WIDTH(8), .CHANNELS(4), .CNT_W(16)) u_a (
        .clk(clk), .rst(a_rst), .d(a_d), .sel(a_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .op(a_op), .op_sel(a_op_sel), .sel_err(a_sel_err),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .xfer_cnt(a_xfer_cnt)
    );

    operand_select_unit #(.WIDTH(8), .CHANNELS(3), .CNT_W(4)) u_b (
        .clk(clk), .rst(b_rst), .d(b_d), .sel(b_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .op(b_op), .op_sel(b_op_sel), .sel_err(b_sel_err),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .xfer_cnt(b_xfer_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model for A: FIFO of held operands (depth 2) plus a count.
    typedef struct {
        logic [7:0] data;
        logic [1:0] sel;
    } ent_t;
    ent_t        mq[$];
    logic [15:0] mcnt;

    task automatic tick();
        bit   acc, xfr;
        ent_t e;
        acc    = a_in_valid && (mq.size() < 2);
        xfr    = (mq.size() > 0) && a_out_ready;
        e.sel  = a_sel;
        e.data = 8'((a_d >> (32'(a_sel) * 8)) & 32'hFF);
        @(posedge clk);
        if (xfr) begin
            void'(mq.pop_front());
            mcnt = mcnt + 16'd1;
        end
        if (acc) mq.push_back(e);
        #1;
    endtask

    task automatic model_check();
        chk("rnd_out_valid", 32'(a_out_valid), 32'(mq.size() > 0));
        chk("rnd_in_ready", 32'(a_in_ready), 32'(mq.size() < 2));
        chk("rnd_xfer_cnt", 32'(a_xfer_cnt), 32'(mcnt));
        if (mq.size() > 0) begin
            chk("rnd_op", 32'(a_op), 32'(mq[0].data));
            chk("rnd_op_sel", 32'(a_op_sel), 32'(mq[0].sel));
            chk("rnd_sel_err", 32'(a_sel_err), 32'd0);
        end
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic        iv;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [7:0]  e_op;
        logic [1:0]  e_sel;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vt[12];

    initial begin
        // d: ch3=0x44 ch2=0x33 ch1=0x06 ch0=0x09
        vt[0]  = '{2'd0, 1, 0, 1, 1, 8'h09, 2'd0, 16'd0};
        vt[1]  = '{2'd0, 0, 1, 0, 1, 8'h00, 2'd0, 16'd1};
        vt[2]  = '{2'd0, 1, 1, 1, 1, 8'h09, 2'd0, 16'd1};
        vt[3]  = '{2'd1, 1, 1, 1, 1, 8'h06, 2'd1, 16'd2};
        vt[4]  = '{2'd2, 1, 1, 1, 1, 8'h33, 2'd2, 16'd3};
        vt[5]  = '{2'd3, 1, 1, 1, 1, 8'h44, 2'd3, 16'd4};
        vt[6]  = '{2'd0, 0, 1, 0, 1, 8'h00, 2'd0, 16'd5};
        vt[7]  = '{2'd1, 1, 0, 1, 1, 8'h06, 2'd1, 16'd5};
        vt[8]  = '{2'd2, 1, 0, 1, 0, 8'h06, 2'd1, 16'd5};
        vt[9]  = '{2'd3, 1, 0, 1, 0, 8'h06, 2'd1, 16'd5};
        vt[10] = '{2'd0, 0, 1, 1, 1, 8'h33, 2'd2, 16'd6};
        vt[11] = '{2'd0, 0, 1, 0, 1, 8'h00, 2'd0, 16'd7};

        a_rst = 1'b1; a_d = 32'h4433_0609; a_sel = '0;
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        b_rst = 1'b1; b_d = 24'h33_0609; b_sel = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        mcnt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_op", 32'(a_op), 32'd0);
        chk("rst_op_sel", 32'(a_op_sel), 32'd0);
        chk("rst_sel_err", 32'(a_sel_err), 32'd0);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_xfer_cnt", 32'(a_xfer_cnt), 32'd0);
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Directed vectors on A
        for (int i = 0; i < 12; i++) begin
            a_sel = vt[i].sel;
            a_in_valid = vt[i].iv;
            a_out_ready = vt[i].ordy;
            tick();
            chk($sformatf("vec%0d_out_valid", i), 32'(a_out_valid), 32'(vt[i].e_ov));
            chk($sformatf("vec%0d_in_ready", i), 32'(a_in_ready), 32'(vt[i].e_ir));
            chk($sformatf("vec%0d_xfer_cnt", i), 32'(a_xfer_cnt), 32'(vt[i].e_cnt));
            if (vt[i].e_ov) begin
                chk($sformatf("vec%0d_op", i), 32'(a_op), 32'(vt[i].e_op));
                chk($sformatf("vec%0d_op_sel", i), 32'(a_op_sel), 32'(vt[i].e_sel));
            end
        end

        // Async reset while FULL
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_sel = 2'd1;
        tick();
        a_sel = 2'd3;
        tick();
        a_in_valid = 1'b0;
        chk("full_in_ready", 32'(a_in_ready), 32'd0);
        #2 a_rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(a_out_valid), 32'd0);
        chk("arst_in_ready", 32'(a_in_ready), 32'd1);
        chk("arst_xfer_cnt", 32'(a_xfer_cnt), 32'd0);
        mq.delete();
        mcnt = '0;
        #2 a_rst = 1'b0;
        a_in_valid = 1'b1; a_sel = 2'd2;
        tick();
        chk("post_rst_op", 32'(a_op), 32'h33);
        chk("post_rst_valid", 32'(a_out_valid), 32'd1);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        tick();
        chk("post_rst_cnt", 32'(a_xfer_cnt), 32'd1);

        // Out-of-range select and counter wrap on B
        b_sel = 2'd3; b_in_valid = 1'b1; b_out_ready = 1'b0;
        tick();
        b_in_valid = 1'b0;
        chk("oor_op", 32'(b_op), 32'd0);
        chk("oor_sel_err", 32'(b_sel_err), 32'd1);
        chk("oor_op_sel", 32'(b_op_sel), 32'd3);
        chk("oor_valid", 32'(b_out_valid), 32'd1);
        tick();
        chk("oor_held_err", 32'(b_sel_err), 32'd1);
        b_out_ready = 1'b1;
        tick();
        chk("oor_counted", 32'(b_xfer_cnt), 32'd1);
        b_in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b_sel = 2'(i % 3);
            tick();
            chk("b_stream_op", 32'(b_op), 32'((b_d >> (8 * (i % 3))) & 24'hFF));
            chk("b_stream_err", 32'(b_sel_err), 32'd0);
        end
        b_in_valid = 1'b0;
        chk("wrap_pre", 32'(b_xfer_cnt), 32'd0);
        tick();
        chk("wrap_cnt", 32'(b_xfer_cnt), 32'd1);
        chk("wrap_empty", 32'(b_out_valid), 32'd0);

        // Random traffic on A against the model
        for (int i = 0; i < 400; i++) begin
            a_d = $urandom;
            a_sel = 2'($urandom_range(0, 3));
            a_in_valid = ($urandom_range(0, 3) != 0);
            a_out_ready = ($urandom_range(0, 2) != 0);
            tick();
            model_check();
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        repeat (3) begin
            tick();
            model_check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/operand_select_unit.md
# operand_select_unit

Parametrised, pipelined successor to the CPU's 2:1 accumulator operand mux. It selects one of `CHANNELS` `WIDTH`-bit operand sources and registers the result. A valid/ready handshake with a two-entry skid buffer lets the datapath stall without losing operands. It sits between the register/immediate sources and the ALU A-input, and also flags out-of-range selects and counts delivered operands.

## Interface
Parameters:
- `WIDTH`, 8, operand width in bits (≥1)
- `CHANNELS`, 4, number of source channels (≥2)
- `CNT_W`, 16, width of delivered-operand counter
- derived localparam `SEL_W` = max(1, clog2(CHANNELS))

Ports:
- `clk` input 1 — single clock, rising edge
- `rst` input 1 — reset, asynchronous, active-high
- `d` input `CHANNELS*WIDTH` — flattened sources; channel k occupies bits [k*WIDTH +: WIDTH]
- `sel` input `SEL_W` — channel select, sampled on accept
- `in_valid` input 1 — source offers an operand
- `in_ready` output 1 — unit can accept; registered
- `op` output `WIDTH` — selected operand (registered)
- `op_sel` output `SEL_W` — `sel` value that produced `op`
- `sel_err` output 1 — `op` came from an out-of-range select
- `out_valid` output 1 — `op`/`op_sel`/`sel_err` are valid
- `out_ready` input 1 — consumer takes the operand
- `xfer_cnt` output `CNT_W` — count of completed output transfers

## Operation
- Accept: `in_valid && in_ready` on a rising edge. Output transfer: `out_valid && out_ready`.
- Mux: for `sel < CHANNELS`, data = channel `sel`, err = 0. For `sel >= CHANNELS` (only possible when CHANNELS is not a power of 2), data = 0 and err = 1. The entry is still accepted and delivered; an error is never dropped.
- Storage: output register (OUT) plus skid register (SKID). Each holds {data, sel, err, valid}.
- States, encoded by valid bits:
  - EMPTY: OUT=0, SKID=0
  - ONE: OUT=1, SKID=0
  - FULL: OUT=1, SKID=1
- EMPTY + accept → ONE. New entry goes to OUT.
- ONE + accept + transfer → ONE. New entry replaces OUT.
- ONE + accept, no transfer → FULL. New entry goes to SKID.
- ONE + transfer, no accept → EMPTY.
- FULL + transfer → ONE. SKID moves to OUT. No accept is possible because `in_ready`=0.
- FULL, no transfer → FULL. All registers hold.
- `in_ready` = !SKID.valid, taken from a register, with no combinational path from `out_ready`.
- Order is strictly FIFO. No entry is duplicated or lost.
- `xfer_cnt` increments by 1 per output transfer and wraps modulo 2^CNT_W.
- While `out_valid`=1 and `out_ready`=0, `op`, `op_sel` and `sel_err` are stable.

## Timing
- Reset (asynchronous, immediate): OUT and SKID invalid, `op`=0, `op_sel`=0, `sel_err`=0, `out_valid`=0, `xfer_cnt`=0, `in_ready`=1.
- Reset asserted mid-operation discards both entries. The first accept is allowed on the first rising edge after `rst` deasserts.
- Latency: an operand accepted at edge N is on `op` with `out_valid`=1 after edge N (one cycle).
- Throughput: 1 operand/cycle while `out_ready`=1.
- `in_ready` falls the cycle after the SKID fill. It rises the cycle after the SKID drain.
- Simultaneous accept and transfer in ONE: `op` updates to the new operand next cycle, and `xfer_cnt` increments.
- `xfer_cnt` at all-ones plus a transfer → 0.

## Test plan
- Reset/basic: WIDTH=8, CHANNELS=4, d={ch3=0x44, ch2=0x33, ch1=6, ch0=9}. Apply rst, then accept sel=0 → next cycle `op`=9, `out_valid`=1, `xfer_cnt`=0. With `out_ready`=1, `xfer_cnt`=1.
- Streaming: `out_ready`=1, sel=0,1,2,3 on consecutive cycles → `op`=9,6,0x33,0x44 on consecutive cycles, `in_ready` stays 1, `xfer_cnt`=4.
- Backpressure/skid: `out_ready`=0, accept sel=1 then sel=2 → `in_ready`=0, `op` holds 6. Raise `out_ready` → 6 then 0x33 are delivered in order, and `in_ready` returns to 1 one cycle after the drain.
- Out-of-range: CHANNELS=3, accept sel=3 → `op`=0, `sel_err`=1, `op_sel`=3. The transfer is counted.
- Reset mid-stall: FULL state, assert `rst` asynchronously between edges → `out_valid`=0 and `in_ready`=1 immediately. After release, the next operand is delivered normally.
- Counter wrap: CNT_W=4, 17 transfers → `xfer_cnt`=1.
